// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if
//   Bundles the byte-feeder signals so the core-side write port, the status
//   outputs and the transmitter handshake travel as one connection.
//   Signals:
//     i_Wr_DV / i_Wr_Byte   single-cycle byte write from core logic
//     i_Flush               discard every queued byte
//     i_Clr_Ovf             clear the sticky overflow and watchdog flags
//     o_Full / o_Empty      registered occupancy flags
//     o_Count               bytes queued, in-flight head included
//     o_Overflow            sticky: a write was dropped while full
//     o_Tx_Error            sticky: a frame was aborted by the watchdog
//     o_Sent_Count          completed frames, wraps at 16 bits
//     o_Tx_DV / o_Tx_Byte   launch strobe and byte to the transmitter
//     i_Tx_Active/i_Tx_Done transmitter busy level and end-of-frame pulse
//   Modports: slave = the feeder itself, master = whatever drives it.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              i_Wr_DV;
    logic [7:0]        i_Wr_Byte;
    logic              i_Flush;
    logic              i_Clr_Ovf;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_Tx_Error;
    logic [15:0]       o_Sent_Count;
    logic              o_Tx_DV;
    logic [7:0]        o_Tx_Byte;
    logic              i_Tx_Active;
    logic              i_Tx_Done;

    modport master (
        output i_Wr_DV, i_Wr_Byte, i_Flush, i_Clr_Ovf, i_Tx_Active, i_Tx_Done,
        input  o_Full, o_Empty, o_Count, o_Overflow, o_Tx_Error, o_Sent_Count,
               o_Tx_DV, o_Tx_Byte
    );

    modport slave (
        input  i_Wr_DV, i_Wr_Byte, i_Flush, i_Clr_Ovf, i_Tx_Active, i_Tx_Done,
        output o_Full, o_Empty, o_Count, o_Overflow, o_Tx_Error, o_Sent_Count,
               o_Tx_DV, o_Tx_Byte
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO plus launch controller in front of a UART transmitter. Bytes
//   are queued from single-cycle write strobes; the head byte is presented to
//   the transmitter with a DV/Active/Done handshake and stays in the FIFO
//   until the frame completes (or the watchdog aborts it).
//   Ports:
//     i_Clock   system clock, rising edge
//     i_Rst_n   asynchronous active-low reset
//     bus       uart_tx_feeder_if.slave (write port, status, tx handshake)
module uart_tx_feeder #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                  i_Clock,
    input  logic                  i_Rst_n,
    uart_tx_feeder_if.slave       bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_ACT  = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [7:0]         mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [ADDR_W:0]    count;
    logic [ADDR_W:0]    count_next;
    logic               head_valid;
    logic [WD_W-1:0]    wd_cnt;
    logic [WD_W-1:0]    wd_next;

    logic               full;
    logic               empty;
    logic               overflow;
    logic               tx_error;
    logic [15:0]        sent_count;
    logic               tx_dv;
    logic [7:0]         tx_byte;

    logic               wr_ok;
    logic               ovf_set;
    logic               launch;
    logic               act_seen;
    logic               done_evt;
    logic               abort;
    logic               pop;
    logic               wd_hit;

    // Flush takes precedence over a same-cycle write: the write is silently
    // dropped and is not counted as an overflow.
    assign wr_ok   = bus.i_Wr_DV && (count != FULL_CNT) && !bus.i_Flush;
    assign ovf_set = bus.i_Wr_DV && (count == FULL_CNT) && !bus.i_Flush;
    assign wd_hit  = (wd_cnt == WD_LAST);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        act_seen   = 1'b0;
        done_evt   = 1'b0;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if ((count != '0) && !bus.i_Flush) begin
                    launch     = 1'b1;
                    state_next = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                // The exit event wins over a coincident watchdog expiry.
                if (bus.i_Tx_Active) begin
                    act_seen   = 1'b1;
                    state_next = S_WAIT_DONE;
                end else if (wd_hit) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.i_Tx_Done) begin
                    done_evt   = 1'b1;
                    state_next = S_IDLE;
                end else if (wd_hit) begin
                    abort      = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A flushed head has already been discarded, so it must not be popped
    // again when its frame finishes.
    assign pop = (done_evt || abort) && head_valid && !bus.i_Flush;

    always_comb begin
        count_next = count;
        if (bus.i_Flush) begin
            count_next = '0;
        end else if (wr_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !wr_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Watchdog restarts on every state change and only counts while a frame
    // is outstanding.
    always_comb begin
        wd_next = '0;
        if ((state_next == state) && (state != S_IDLE)) begin
            wd_next = wd_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.i_Wr_Byte;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            head_valid <= 1'b0;
            wd_cnt     <= '0;
            overflow   <= 1'b0;
            tx_error   <= 1'b0;
            sent_count <= '0;
            tx_dv      <= 1'b0;
            tx_byte    <= '0;
        end else begin
            count  <= count_next;
            full   <= (count_next == FULL_CNT);
            empty  <= (count_next == '0);
            wd_cnt <= wd_next;

            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (bus.i_Flush) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            // tx_byte is only loaded on launch, which happens in S_IDLE, so it
            // is frozen for the whole frame.
            if (launch) begin
                tx_byte <= mem[rd_ptr];
                tx_dv   <= 1'b1;
            end else if (act_seen || abort) begin
                tx_dv   <= 1'b0;
            end

            if (launch) begin
                head_valid <= 1'b1;
            end else if (bus.i_Flush || done_evt || abort) begin
                head_valid <= 1'b0;
            end

            if (done_evt) begin
                sent_count <= sent_count + 16'd1;
            end

            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (bus.i_Clr_Ovf) begin
                overflow <= 1'b0;
            end

            if (abort) begin
                tx_error <= 1'b1;
            end else if (bus.i_Clr_Ovf) begin
                tx_error <= 1'b0;
            end
        end
    end

    assign bus.o_Full       = full;
    assign bus.o_Empty      = empty;
    assign bus.o_Count      = count;
    assign bus.o_Overflow   = overflow;
    assign bus.o_Tx_Error   = tx_error;
    assign bus.o_Sent_Count = sent_count;
    assign bus.o_Tx_DV      = tx_dv;
    assign bus.o_Tx_Byte    = tx_byte;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder
//   Directed bench for uart_tx_feeder. Inputs change on the falling edge and
//   outputs are observed on the falling edge. A hand-driven transmitter stub
//   raises Active, holds it for FRAME cycles, then pulses Done.
module tb_uart_tx_feeder;
    localparam int DEPTH = 16;
    localparam int TO    = 64;
    localparam int FRAME = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    int n_cmp    = 0;
    int n_err    = 0;
    int exp_sent = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.i_Wr_DV   = 1'b1;
        bus.i_Wr_Byte = b;
        @(negedge clk);
        bus.i_Wr_DV   = 1'b0;
    endtask

    task automatic wait_dv();
        int waited;
        waited = 0;
        while (bus.o_Tx_DV !== 1'b1 && waited < 80) begin
            @(negedge clk);
            waited++;
        end
        chk("dv_wait", 32'(bus.o_Tx_DV), 1);
    endtask

    // One complete frame through the stub transmitter. Optionally a write
    // and/or a flush is driven in the first cycle after Active is seen.
    task automatic send_frame(input logic [7:0] exp_b, input logic do_wr,
                              input logic [7:0] wr_b, input logic do_flush);
        logic held;
        wait_dv();
        chk("tx_byte", 32'(bus.o_Tx_Byte), 32'(exp_b));
        bus.i_Tx_Active = 1'b1;
        @(negedge clk);
        chk("dv_drop", 32'(bus.o_Tx_DV), 0);
        bus.i_Wr_DV   = do_wr;
        bus.i_Wr_Byte = wr_b;
        bus.i_Flush   = do_flush;
        @(negedge clk);
        bus.i_Wr_DV   = 1'b0;
        bus.i_Flush   = 1'b0;
        held = 1'b1;
        for (int k = 0; k < FRAME; k++) begin
            if (bus.o_Tx_Byte !== exp_b || bus.o_Tx_DV !== 1'b0) held = 1'b0;
            @(negedge clk);
        end
        chk("byte_held", 32'(held), 1);
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b1;
        @(negedge clk);
        bus.i_Tx_Done   = 1'b0;
        exp_sent++;
        chk("sent_count", 32'(bus.o_Sent_Count), 32'(exp_sent));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int dv_seen;
        bus.i_Wr_DV     = 1'b0;
        bus.i_Wr_Byte   = 8'h00;
        bus.i_Flush     = 1'b0;
        bus.i_Clr_Ovf   = 1'b0;
        bus.i_Tx_Active = 1'b0;
        bus.i_Tx_Done   = 1'b0;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dv",    32'(bus.o_Tx_DV), 0);
        chk("rst_byte",  32'(bus.o_Tx_Byte), 0);
        chk("rst_full",  32'(bus.o_Full), 0);
        chk("rst_empty", 32'(bus.o_Empty), 1);
        chk("rst_count", 32'(bus.o_Count), 0);
        chk("rst_ovf",   32'(bus.o_Overflow), 0);
        chk("rst_err",   32'(bus.o_Tx_Error), 0);
        chk("rst_sent",  32'(bus.o_Sent_Count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Single byte: count=1 right after the write, DV one edge later
        write_byte(8'hA5);
        chk("t1_count", 32'(bus.o_Count), 1);
        chk("t1_dv_not_yet", 32'(bus.o_Tx_DV), 0);
        @(negedge clk);
        chk("t1_dv_next", 32'(bus.o_Tx_DV), 1);
        send_frame(8'hA5, 1'b0, 8'h00, 1'b0);
        chk("t1_empty", 32'(bus.o_Empty), 1);
        chk("t1_count0", 32'(bus.o_Count), 0);

        // 2. Burst to full, one dropped write, drain in order
        for (int i = 1; i <= 16; i++) write_byte(8'(i));
        chk("t2_full", 32'(bus.o_Full), 1);
        chk("t2_count16", 32'(bus.o_Count), 16);
        chk("t2_ovf_clear", 32'(bus.o_Overflow), 0);
        write_byte(8'h11);
        chk("t2_ovf_set", 32'(bus.o_Overflow), 1);
        chk("t2_count_hold", 32'(bus.o_Count), 16);
        for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b0, 8'h00, 1'b0);
        chk("t2_sent", 32'(bus.o_Sent_Count), 17);
        chk("t2_empty", 32'(bus.o_Empty), 1);
        chk("t2_not_full", 32'(bus.o_Full), 0);
        bus.i_Clr_Ovf = 1'b1;
        @(negedge clk);
        bus.i_Clr_Ovf = 1'b0;
        chk("t2_ovf_cleared", 32'(bus.o_Overflow), 0);

        // 3. Streaming 40 bytes with pointer wrap
        for (int i = 0; i < 8; i++) write_byte(8'(8'h80 + i));
        chk("t3_prefill", 32'(bus.o_Count), 8);
        for (int i = 0; i < 40; i++)
            send_frame(8'(8'h80 + i), (i + 8 < 40), 8'(8'h80 + i + 8), 1'b0);
        chk("t3_sent", 32'(bus.o_Sent_Count), 57);
        chk("t3_empty", 32'(bus.o_Empty), 1);
        chk("t3_no_ovf", 32'(bus.o_Overflow), 0);

        // 4. Flush during frame 0x11 with a colliding write of 0x44
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        send_frame(8'h11, 1'b1, 8'h44, 1'b1);
        chk("t4_count", 32'(bus.o_Count), 0);
        chk("t4_empty", 32'(bus.o_Empty), 1);
        chk("t4_no_ovf", 32'(bus.o_Overflow), 0);
        dv_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.o_Tx_DV === 1'b1) dv_seen++;
        end
        chk("t4_no_more_dv", 32'(dv_seen), 0);
        chk("t4_sent", 32'(bus.o_Sent_Count), 58);

        // 5. Watchdog: transmitter never responds
        write_byte(8'h5A);
        wait_dv();
        chk("t5_byte", 32'(bus.o_Tx_Byte), 'h5A);
        repeat (TO - 1) @(negedge clk);
        chk("t5_dv_before", 32'(bus.o_Tx_DV), 1);
        chk("t5_err_before", 32'(bus.o_Tx_Error), 0);
        @(negedge clk);
        chk("t5_err", 32'(bus.o_Tx_Error), 1);
        chk("t5_dv", 32'(bus.o_Tx_DV), 0);
        chk("t5_count", 32'(bus.o_Count), 0);
        chk("t5_sent", 32'(bus.o_Sent_Count), 58);
        bus.i_Clr_Ovf = 1'b1;
        @(negedge clk);
        bus.i_Clr_Ovf = 1'b0;
        chk("t5_err_cleared", 32'(bus.o_Tx_Error), 0);

        // 6. Asynchronous reset in the middle of a frame
        write_byte(8'hB1);
        write_byte(8'hB2);
        write_byte(8'hB3);
        wait_dv();
        bus.i_Tx_Active = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_dv",    32'(bus.o_Tx_DV), 0);
        chk("t6_byte",  32'(bus.o_Tx_Byte), 0);
        chk("t6_empty", 32'(bus.o_Empty), 1);
        chk("t6_count", 32'(bus.o_Count), 0);
        chk("t6_sent",  32'(bus.o_Sent_Count), 0);
        chk("t6_full",  32'(bus.o_Full), 0);
        @(negedge clk);
        bus.i_Tx_Active = 1'b0;
        rst_n = 1'b1;
        dv_seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.o_Tx_DV === 1'b1) dv_seen++;
        end
        chk("t6_no_dv", 32'(dv_seen), 0);
        chk("t6_count_after", 32'(bus.o_Count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
